exe_muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execute stage. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation at a time through a valid/ready handshake. Multiplication and division are computed one bit per cycle, and results are committed to HI/LO on completion. A flush input aborts an in-flight operation without touching HI/LO, so exceptions and ERET arriving from later stages leave architectural state clean.

---
 rtl/exe_muldiv_unit.sv | 96 +++++++++
 tb/tb_exe_muldiv_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit: iterative shift-add multiply / restoring divide with HI/LO registers and flush abort
module exe_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  output logic             busy,
  output logic             res_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, opd_q, opd_d, mag1, mag2;
  logic [2*WIDTH-1:0] acc_q, acc_d, step, res;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d, rneg_q, rneg_d;
  logic [WIDTH:0]     sum, dif;
  logic               s1, s2, accept, last;
  always_comb begin
    accept  = op_valid && state_q == IDLE && !flush;
    s1      = !op[0] && src1[WIDTH-1];
    s2      = !op[0] && src2[WIDTH-1];
    mag1    = s1 ? -src1 : src1;
    mag2    = s2 ? -src2 : src2;
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? opd_q : {WIDTH{1'b0}}};
    dif     = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opd_q};
    step    = state_q == MUL ? {sum, acc_q[WIDTH-1:1]}
            : dif[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
            : {dif[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    res     = state_q == MUL ? (neg_q ? -step : step)
            : {rneg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH],
               neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0]};
    last    = cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opd_d   = opd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    if (accept) begin
      hi_d = op == 3'b100 ? src1 : hi_q;
      lo_d = op == 3'b101 ? src1 : lo_q;
      if (!op[2]) begin
        state_d = op[1] ? DIV : MUL;
        opd_d   = op[1] ? mag2 : mag1;
        acc_d   = {{WIDTH{1'b0}}, op[1] ? mag1 : mag2};
        cnt_d   = '0;
        neg_d   = (s1 ^ s2) && !(op[1] && src2 == '0);
        rneg_d  = s1;
      end
    end else if (state_q == MUL || state_q == DIV) begin
      acc_d   = step;
      cnt_d   = cnt_q + 1'b1;
      state_d = flush ? IDLE : last ? DONE : state_q;
      if (last && !flush) {hi_d, lo_d} = res;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      opd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opd_q   <= opd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end
  assign op_ready  = state_q == IDLE;
  assign busy      = state_q == MUL || state_q == DIV;
  assign res_valid = state_q == DONE;
  assign hi        = hi_q;
  assign lo        = lo_q;
endmodule

// File: tb/tb_exe_muldiv_unit.sv
// tb_exe_muldiv_unit: randomized scoreboard bench for 32- and 8-bit instances of exe_muldiv_unit
module tb_exe_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, rst8, v32, v8, flush;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        ready32, busy32, rv32, ready8, busy8, rv8;
  logic [31:0] hi32, lo32, m_hi, m_lo;
  logic [7:0]  hi8, lo8;
  logic [63:0] q32[$];
  logic [15:0] q8[$];
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  exe_muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .op_valid(v32), .op_ready(ready32), .op(op),
    .src1(src1), .src2(src2), .flush(flush), .busy(busy32), .res_valid(rv32),
    .hi(hi32), .lo(lo32)
  );

  exe_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .op_valid(v8), .op_ready(ready8), .op(op),
    .src1(src1[7:0]), .src2(src2[7:0]), .flush(flush), .busy(busy8), .res_valid(rv8),
    .hi(hi8), .lo(lo8)
  );

  task automatic check(input string n, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  // Architectural result {hi,lo} from plain integer arithmetic on w-bit operands.
  function automatic logic [63:0] model(input int w, input logic [2:0] o, input longint a_in, input longint b_in);
    longint m, a, b, sa, sb, q, r, p;
    m  = (longint'(1) << w) - 1;
    a  = a_in & m;
    b  = b_in & m;
    sa = ((a >> (w - 1)) & 1) != 0 ? a - (m + 1) : a;
    sb = ((b >> (w - 1)) & 1) != 0 ? b - (m + 1) : b;
    if (!o[1]) begin
      p = o[0] ? a * b : sa * sb;
      return (w == 32) ? p : p & ((longint'(1) << (2 * w)) - 1);
    end
    if (b == 0) begin
      q = m;
      r = a;
    end else if (o[0]) begin
      q = a / b;
      r = a % b;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return ((r & m) << w) | (q & m);
  endfunction

  always @(negedge clk) begin
    if (rv32) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL res32 unexpected res_valid hi=%0h lo=%0h", hi32, lo32);
      end else begin
        logic [63:0] e;
        e = q32.pop_front();
        if ({hi32, lo32} !== e) begin
          errors++;
          $display("FAIL res32 got %0h want %0h", {hi32, lo32}, e);
        end
      end
    end
    if (rv8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL res8 unexpected res_valid hi=%0h lo=%0h", hi8, lo8);
      end else begin
        logic [15:0] e;
        e = q8.pop_front();
        if ({hi8, lo8} !== e) begin
          errors++;
          $display("FAIL res8 got %0h want %0h", {hi8, lo8}, e);
        end
      end
    end
  end

  task automatic start(input int w, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op   = o;
    src1 = a;
    src2 = b;
    if (w == 32) v32 = 1'b1;
    else v8 = 1'b1;
    @(posedge clk);
    #1;
    v32 = 1'b0;
    v8  = 1'b0;
  endtask

  task automatic issue(input int w, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int k, nb;
    logic [63:0] e;
    start(w, o, a, b);
    if (o[2]) begin
      if (w == 32 && o == 3'b100) m_hi = a;
      if (w == 32 && o == 3'b101) m_lo = a;
      return;
    end
    e = model(w, o, longint'(a), longint'(b));
    if (w == 32) begin
      q32.push_back(e);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end else q8.push_back(e[15:0]);
    k  = 0;
    nb = 0;
    do begin
      @(negedge clk);
      k++;
      if (w == 32 ? busy32 : busy8) nb++;
    end while (!(w == 32 ? rv32 : rv8) && k < w + 5);
    check("latency", k, w + 1);
    check("busy_cycles", nb, w);
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; rst8 = 1'b1; v32 = 1'b0; v8 = 1'b0; flush = 1'b0;
    op = '0; src1 = '0; src2 = '0; m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    rst8  = 1'b0;
    @(negedge clk);
    check("reset_hi", hi32, 0);
    check("reset_lo", lo32, 0);
    check("reset_busy", busy32, 0);
    check("reset_ready", ready32, 1);
    check("reset_rv", rv32, 0);

    issue(32, 3'b000, 32'hFFFFFFFE, 32'd3);
    check("mult_hi", hi32, 32'hFFFFFFFF);
    check("mult_lo", lo32, 32'hFFFFFFFA);
    issue(32, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_hi", hi32, 32'hFFFFFFFE);
    check("multu_lo", lo32, 32'h00000001);
    issue(32, 3'b010, 32'hFFFFFFF9, 32'd2);
    check("div_lo", lo32, 32'hFFFFFFFD);
    check("div_hi", hi32, 32'hFFFFFFFF);
    issue(32, 3'b011, 32'd7, 32'd0);
    check("divz_lo", lo32, 32'hFFFFFFFF);
    check("divz_hi", hi32, 32'h7);
    issue(32, 3'b010, 32'h80000000, 32'hFFFFFFFF);
    check("ovf_lo", lo32, 32'h80000000);
    check("ovf_hi", hi32, 32'h0);
    issue(32, 3'b010, 32'hFFFFFFF9, 32'd0);
    check("sdivz_hi", hi32, 32'hFFFFFFF9);

    issue(32, 3'b100, 32'hAAAA, 32'h0);
    issue(32, 3'b101, 32'h5555, 32'h0);
    @(negedge clk);
    check("mthi", hi32, 32'hAAAA);
    check("mtlo", lo32, 32'h5555);

    start(32, 3'b011, 32'd100, 32'd3);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_ready", ready32, 1);
    check("flush_hi", hi32, 32'hAAAA);
    check("flush_lo", lo32, 32'h5555);
    repeat (40) @(negedge clk);
    check("flush_hi_later", hi32, 32'hAAAA);
    issue(32, 3'b001, 32'd6, 32'd7);
    check("mul42_lo", lo32, 32'd42);
    check("mul42_hi", hi32, 32'd0);

    start(32, 3'b001, 32'd123, 32'd456);
    repeat (32) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("lastflush_rv", rv32, 0);
    check("lastflush_hi", hi32, m_hi);
    check("lastflush_lo", lo32, m_lo);
    check("lastflush_ready", ready32, 1);

    @(negedge clk);
    op = 3'b100; src1 = 32'hDEAD; v32 = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    op = 3'b001;
    @(posedge clk);
    #1;
    v32 = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idleflush_hi", hi32, m_hi);
    check("idleflush_busy", busy32, 0);

    for (int i = 0; i < 40; i++) begin
      issue(32, 3'($urandom_range(0, 7)), rnd(), rnd());
      @(negedge clk);
      check("rand_hi", hi32, m_hi);
      check("rand_lo", lo32, m_lo);
    end

    issue(8, 3'b000, 32'h80, 32'h80);
    check("w8_hi", hi8, 8'h40);
    check("w8_lo", lo8, 8'h00);
    for (int i = 0; i < 12; i++) issue(8, 3'($urandom_range(0, 3)), $urandom, $urandom);
    start(8, 3'b010, 32'h75, 32'h3);
    repeat (4) @(negedge clk);
    rst8 = 1'b1;
    @(posedge clk);
    #1;
    rst8 = 1'b0;
    @(negedge clk);
    check("w8rst_hi", hi8, 0);
    check("w8rst_lo", lo8, 0);
    check("w8rst_busy", busy8, 0);
    check("w8rst_ready", ready8, 1);

    repeat (12) @(negedge clk);
    check("queue_empty", q32.size() + q8.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
